sha256_compress: RTL and testbench



---
 rtl/sha256_pkg.sv | 65 ++++++
 rtl/sha256_msg_sched.sv | 39 +++
 rtl/sha256_compress.sv | 134 +++++++++++++
 tb/tb_sha256_compress.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// Shared SHA-256 types, constants and bit-mixing functions for the compression engine.
package sha256_pkg;

    typedef logic [0:7][31:0] hash_t;

    typedef enum logic {
        LOAD  = 1'b0,
        SCHED = 1'b1
    } state_t;

    localparam hash_t IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [6:0] K_IDLE_SEL = 7'h7F;
    localparam logic [5:0] LAST_LOAD  = 6'd15;
    localparam logic [5:0] LAST_ROUND = 6'd63;

    function automatic logic [31:0] big_sigma0(input logic [31:0] x);
        return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
    endfunction

    function automatic logic [31:0] big_sigma1(input logic [31:0] x);
        return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
    endfunction

    function automatic logic [31:0] small_sigma0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [31:0] small_sigma1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

    function automatic logic [31:0] ch(input logic [31:0] e, input logic [31:0] f,
                                       input logic [31:0] g);
        return (e & f) ^ (~e & g);
    endfunction

    function automatic logic [31:0] maj(input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] c);
        return (a & b) ^ (a & c) ^ (b & c);
    endfunction

    // One compression round on the working set {a..h}; element 0 is a.
    function automatic hash_t sha256_round(input hash_t s, input logic [31:0] w,
                                           input logic [31:0] k);
        logic [31:0] t1;
        logic [31:0] t2;
        hash_t       r;
        t1   = s[7] + big_sigma1(s[4]) + ch(s[4], s[5], s[6]) + k + w;
        t2   = big_sigma0(s[0]) + maj(s[0], s[1], s[2]);
        r[0] = t1 + t2;
        r[1] = s[0];
        r[2] = s[1];
        r[3] = s[2];
        r[4] = s[3] + t1;
        r[5] = s[4];
        r[6] = s[5];
        r[7] = s[6];
        return r;
    endfunction

endpackage

// File: rtl/sha256_msg_sched.sv
// 16-word message schedule window: passes input words through while loading,
// otherwise expands W_t from the window; every push shifts W_t in as the newest word.
module sha256_msg_sched
    import sha256_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic        load,
    input  logic [31:0] w_data,
    output logic [31:0] w_t
);

    // Index 15 holds W[t-1]; index 16-j holds W[t-j].
    logic [15:0][31:0] win_reg;
    logic [15:0][31:0] win_next;
    logic [31:0]       sched_w;

    assign sched_w = small_sigma1(win_reg[14]) + win_reg[9]
                   + small_sigma0(win_reg[1]) + win_reg[0];
    assign w_t = load ? w_data : sched_w;

    genvar gi;
    generate
        for (gi = 0; gi < 15; gi++) begin : g_shift
            assign win_next[gi] = win_reg[gi + 1];
        end
    endgenerate
    assign win_next[15] = w_t;

    always_ff @(posedge clk) begin
        if (rst) begin
            win_reg <= '0;
        end else if (push) begin
            win_reg <= win_next;
        end
    end

endmodule

// File: rtl/sha256_compress.sv
// SHA-256 compression engine: 16 serial words in, 64 rounds at one per cycle,
// result folded into the chaining value with a one-cycle digest_valid pulse.
module sha256_compress
    import sha256_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         w_valid,
    output logic         w_ready,
    input  logic [31:0]  w_data,
    input  logic         first_blk,
    output logic [6:0]   k_sel,
    input  logic [31:0]  k_in,
    output logic [255:0] digest,
    output logic         digest_valid,
    output logic         busy
);

    state_t      state_reg;
    state_t      state_next;
    logic [5:0]  t_reg;
    logic [5:0]  t_next;
    hash_t       h_reg;
    hash_t       work_reg;
    hash_t       round_in;
    hash_t       round_out;
    hash_t       fold_base;
    hash_t       h_sum;
    logic        new_msg_reg;
    logic        dv_reg;
    logic        fire;
    logic        last;
    logic        load_mode;
    logic [31:0] w_t;

    assign load_mode = (state_reg == LOAD);

    sha256_msg_sched u_msg_sched (
        .clk    (clk),
        .rst    (rst),
        .push   (fire),
        .load   (load_mode),
        .w_data (w_data),
        .w_t    (w_t)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= LOAD;
            t_reg     <= '0;
        end else begin
            state_reg <= state_next;
            t_reg     <= t_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        t_next     = t_reg;
        fire       = 1'b0;
        last       = 1'b0;
        w_ready    = 1'b0;
        busy       = 1'b0;
        k_sel      = K_IDLE_SEL;
        case (state_reg)
            LOAD: begin
                w_ready = 1'b1;
                if (w_valid) begin
                    k_sel  = {1'b0, t_reg};
                    fire   = 1'b1;
                    t_next = t_reg + 6'd1;
                    if (t_reg == LAST_LOAD) begin
                        state_next = SCHED;
                    end
                end
            end
            SCHED: begin
                busy   = 1'b1;
                k_sel  = {1'b0, t_reg};
                fire   = 1'b1;
                t_next = t_reg + 6'd1;
                if (t_reg == LAST_ROUND) begin
                    last       = 1'b1;
                    state_next = LOAD;
                end
            end
            default: state_next = LOAD;
        endcase
        // Reset dominates: nothing is accepted, no round runs, outputs idle.
        if (rst) begin
            fire    = 1'b0;
            last    = 1'b0;
            w_ready = 1'b0;
            busy    = 1'b0;
            k_sel   = K_IDLE_SEL;
        end
    end

    // A new message starts from IV both for the rounds and for the final fold.
    assign round_in  = (t_reg == 6'd0) ? (first_blk ? IV : h_reg) : work_reg;
    assign round_out = sha256_round(round_in, w_t, k_in);
    assign fold_base = new_msg_reg ? IV : h_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_fold
            assign h_sum[gi] = fold_base[gi] + round_out[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            h_reg       <= IV;
            work_reg    <= IV;
            new_msg_reg <= 1'b0;
            dv_reg      <= 1'b0;
        end else begin
            dv_reg <= last;
            if (fire && load_mode && (t_reg == 6'd0)) begin
                new_msg_reg <= first_blk;
            end
            if (last) begin
                h_reg    <= h_sum;
                work_reg <= h_sum;
            end else if (fire) begin
                work_reg <= round_out;
            end
        end
    end

    assign digest       = h_reg;
    assign digest_valid = dv_reg;

endmodule

// File: tb/tb_sha256_compress.sv
// Self-checking bench for sha256_compress: known vectors plus random blocks
// checked against a straightforward full-schedule SHA-256 reference.
module tb_sha256_compress;

    typedef logic [31:0] blk_t [16];

    localparam logic [255:0] IV_VAL =
        256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam logic [255:0] ABC_DIGEST =
        256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] TWO_BLK_DIGEST =
        256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

    localparam logic [31:0] K_TAB [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         w_valid = 1'b0;
    logic         w_ready;
    logic [31:0]  w_data = '0;
    logic         first_blk = 1'b0;
    logic [6:0]   k_sel;
    logic [31:0]  k_in;
    logic [255:0] digest;
    logic         digest_valid;
    logic         busy;

    sha256_compress dut (
        .clk          (clk),
        .rst          (rst),
        .w_valid      (w_valid),
        .w_ready      (w_ready),
        .w_data       (w_data),
        .first_blk    (first_blk),
        .k_sel        (k_sel),
        .k_in         (k_in),
        .digest       (digest),
        .digest_valid (digest_valid),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // k_file stand-in: 64-entry ROM, 0 for any out-of-range selector.
    always_comb begin
        k_in = 32'h0;
        if (k_sel < 7'd64) k_in = K_TAB[k_sel[5:0]];
    end

    int           n_checks = 0;
    int           n_fail = 0;
    int           cyc = 0;
    int           pulses = 0;
    int           last_pulse_cyc = -1;
    logic [255:0] last_digest = '0;
    logic [255:0] prev_digest = '0;
    bit           prev_dv = 1'b0;
    bit           prev_rst = 1'b1;
    bit           started = 1'b0;
    bit           pending = 1'b0;
    int           pending_cyc = 0;
    logic [255:0] pending_digest = '0;
    logic [255:0] model_h = '0;
    int           blk_start = 0;
    int           gaps = 0;

    task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Textbook compression: full 64-word schedule, then 64 rounds, then fold.
    function automatic logic [255:0] ref_compress(input logic [255:0] hin, input blk_t m);
        logic [31:0] w [64];
        logic [31:0] hh [8];
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2, s0, s1;
        logic [255:0] res;
        for (int i = 0; i < 16; i++) w[i] = m[i];
        for (int i = 16; i < 64; i++) begin
            s0 = rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3);
            s1 = rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10);
            w[i] = w[i-16] + s0 + w[i-7] + s1;
        end
        for (int j = 0; j < 8; j++) hh[j] = hin[255 - 32*j -: 32];
        a = hh[0]; b = hh[1]; c = hh[2]; d = hh[3];
        e = hh[4]; f = hh[5]; g = hh[6]; h = hh[7];
        for (int i = 0; i < 64; i++) begin
            t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + K_TAB[i] + w[i];
            t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            h = g; g = f; f = e; e = d + t1;
            d = c; c = b; b = a; a = t1 + t2;
        end
        res = {hh[0] + a, hh[1] + b, hh[2] + c, hh[3] + d,
               hh[4] + e, hh[5] + f, hh[6] + g, hh[7] + h};
        return res;
    endfunction

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (digest_valid) begin
            check_val("dv_one_cycle", 256'(prev_dv), 256'(0));
            pulses++;
            last_pulse_cyc = cyc;
            last_digest = digest;
        end
        if (started && !rst && !prev_rst && !digest_valid)
            check_val("digest_stable", digest, prev_digest);
        prev_dv = digest_valid;
        prev_rst = rst;
        prev_digest = digest;
    end

    task automatic cycle_begin();
        @(posedge clk);
        #1;
    endtask

    task automatic cycle_end();
        @(negedge clk);
        #1;
    endtask

    task automatic check_pending();
        if (pending) begin
            check_val("pulse_cycle", 256'(last_pulse_cyc), 256'(pending_cyc));
            check_val("digest_model", last_digest, pending_digest);
            pending = 1'b0;
        end
    endtask

    task automatic send_words(input blk_t blk, input bit first, input int mode);
        int gp;
        for (int i = 0; i < 16; i++) begin
            gp = 0;
            if (mode == 1 && (i == 5 || i == 12)) gp = 3;
            else if (mode == 2 && i > 0) gp = int'($urandom_range(0, 2));
            for (int g = 0; g < gp; g++) begin
                cycle_begin();
                w_valid = 1'b0;
                w_data = $urandom;
                first_blk = 1'($urandom_range(0, 1));
                cycle_end();
                check_val("gap_k_sel", 256'(k_sel), 256'(7'h7F));
                check_val("gap_w_ready", 256'(w_ready), 256'(1));
                gaps++;
            end
            cycle_begin();
            w_valid = 1'b1;
            w_data = blk[i];
            first_blk = (i == 0) ? first : 1'($urandom_range(0, 1));
            cycle_end();
            if (i == 0) begin
                blk_start = cyc;
                check_pending();
            end
            check_val("load_k_sel", 256'(k_sel), 256'(i));
            check_val("load_w_ready", 256'(w_ready), 256'(1));
        end
    endtask

    // w_valid stays high throughout: the engine must not consume anything.
    task automatic sched_walk();
        for (int t = 16; t < 64; t++) begin
            cycle_begin();
            w_valid = 1'b1;
            w_data = $urandom;
            first_blk = 1'($urandom_range(0, 1));
            cycle_end();
            check_val("sched_w_ready", 256'(w_ready), 256'(0));
            check_val("sched_k_sel", 256'(k_sel), 256'(t));
            check_val("sched_busy", 256'(busy), 256'(1));
        end
    endtask

    task automatic run_block(input blk_t blk, input bit first, input int mode);
        gaps = 0;
        send_words(blk, first, mode);
        model_h = ref_compress(first ? IV_VAL : model_h, blk);
        sched_walk();
        pending = 1'b1;
        pending_cyc = blk_start + 64 + gaps;
        pending_digest = model_h;
        $display("block done: start=%0d gaps=%0d first=%0d expect %h", blk_start, gaps, first, model_h);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            cycle_begin();
            w_valid = 1'b0;
            w_data = $urandom;
            cycle_end();
            check_pending();
            check_val("idle_k_sel", 256'(k_sel), 256'(7'h7F));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        blk_t abc, m1, m2, rnd;
        int p0;
        bit fb;

        abc = '{default: 32'h0};
        abc[0] = 32'h61626380;
        abc[15] = 32'h00000018;
        m1 = '{32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
               32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
               32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
               32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
        m2 = '{default: 32'h0};
        m2[15] = 32'h000001c0;

        // Reset state
        for (int i = 0; i < 3; i++) begin
            cycle_begin();
            rst = 1'b1;
            w_valid = 1'b1;
            cycle_end();
        end
        check_val("rst_w_ready", 256'(w_ready), 256'(0));
        check_val("rst_k_sel", 256'(k_sel), 256'(7'h7F));
        check_val("rst_busy", 256'(busy), 256'(0));
        check_val("rst_dv", 256'(digest_valid), 256'(0));
        check_val("rst_digest", digest, IV_VAL);
        cycle_begin();
        rst = 1'b0;
        w_valid = 1'b0;
        cycle_end();
        started = 1'b1;
        check_val("idle_w_ready", 256'(w_ready), 256'(1));
        check_val("idle_k_sel0", 256'(k_sel), 256'(7'h7F));

        // "abc" back-to-back
        run_block(abc, 1'b1, 0);
        idle(2);
        check_val("abc_const", last_digest, ABC_DIGEST);

        // Two-block message, no bubble between blocks
        run_block(m1, 1'b1, 0);
        p0 = blk_start;
        run_block(m2, 1'b0, 0);
        check_val("blk2_start", 256'(blk_start), 256'(p0 + 64));
        idle(2);
        check_val("two_blk_cycle", 256'(last_pulse_cyc), 256'(p0 + 128));
        check_val("two_blk_const", last_digest, TWO_BLK_DIGEST);

        // "abc" with 3-cycle stalls after words 4 and 11
        run_block(abc, 1'b1, 1);
        p0 = blk_start;
        idle(2);
        check_val("stall_cycle", 256'(last_pulse_cyc), 256'(p0 + 70));
        check_val("stall_const", last_digest, ABC_DIGEST);

        // Reset at cycle 30 of a block
        gaps = 0;
        send_words(abc, 1'b1, 0);
        for (int t = 16; t < 30; t++) begin
            cycle_begin();
            w_valid = 1'b0;
            cycle_end();
        end
        cycle_begin();
        rst = 1'b1;
        cycle_end();
        check_val("abort_rst_busy", 256'(busy), 256'(0));
        check_val("abort_rst_k_sel", 256'(k_sel), 256'(7'h7F));
        p0 = pulses;
        cycle_begin();
        rst = 1'b0;
        cycle_end();
        idle(70);
        check_val("abort_no_pulse", 256'(pulses), 256'(p0));
        check_val("abort_digest_iv", digest, IV_VAL);
        $display("abort: pulses=%0d digest=%h", pulses, digest);
        run_block(abc, 1'b1, 0);
        idle(2);
        check_val("after_abort_const", last_digest, ABC_DIGEST);

        // "abc" twice, each starting a new message
        run_block(abc, 1'b1, 0);
        run_block(abc, 1'b1, 0);
        idle(2);
        check_val("abc_twice_const", last_digest, ABC_DIGEST);

        // Random chained blocks with random stalls
        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < 16; i++) rnd[i] = $urandom;
            fb = (k == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            run_block(rnd, fb, 2);
        end
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
